// File: rtl/uart_tx_stream.sv
// UART transmitter fed from a valid/ready byte stream.
// Frames are start, LSB-first data, optional parity, then one or two stop bits.
module uart_tx_stream #(
    parameter int DATA_BIT = 8,
    parameter int DIV_BIT  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DIV_BIT-1:0]  baud_div,
    input  logic                parity_en,
    input  logic                parity_odd,
    input  logic                stop2,
    input  logic [DATA_BIT-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                tx,
    output logic                busy,
    output logic                done
);

    localparam int BW = $clog2(DATA_BIT) + 1;
    localparam logic [BW-1:0] LAST = BW'(DATA_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]          state_q,   state_d;
    logic [DIV_BIT-1:0]  cnt_q,     cnt_d;
    logic [DIV_BIT-1:0]  div_q,     div_d;
    logic [BW-1:0]       bit_q,     bit_d;
    logic [DATA_BIT-1:0] sh_q,      sh_d;
    logic                par_en_q,  par_en_d;
    logic                par_bit_q, par_bit_d;
    logic                stop2_q,   stop2_d;
    logic                tx_q,      tx_d;
    logic                done_q,    done_d;

    assign s_ready = (state_q == IDLE) && !reset;
    assign busy    = (state_q != IDLE);
    assign tx      = tx_q;
    assign done    = done_q;

    // Next-state: latch settings on acceptance, then walk bits on baud boundaries
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        if (state_q == IDLE) begin
            if (s_valid) begin
                sh_d      = s_data;
                div_d     = baud_div;
                cnt_d     = baud_div;
                par_en_d  = parity_en;
                // Parity is resolved once here so the frame never needs the raw byte again
                par_bit_d = (^s_data) ^ parity_odd;
                stop2_d   = stop2;
                bit_d     = '0;
                tx_d      = 1'b0;
                state_d   = START;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DIV_BIT'(1);
        end else begin
            cnt_d = div_q;
            case (state_q)
                START: begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = sh_q[0];
                end
                DATA: begin
                    if (bit_q == LAST) begin
                        bit_d = '0;
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + BW'(1);
                        sh_d  = sh_q >> 1;
                        tx_d  = sh_d[0];
                    end
                end
                PARITY: begin
                    state_d = STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
                STOP: begin
                    tx_d = 1'b1;
                    if (stop2_q && (bit_q == '0)) begin
                        bit_d = BW'(1);
                    end else begin
                        bit_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    // State registers; reset aborts any frame and parks the line high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed self-checking bench for uart_tx_stream.
// Samples outputs 1ns after each rising edge.
module tb_uart_tx_stream;

    logic        clk;
    logic        reset;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        stop2;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        tx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0;

    uart_tx_stream #(.DATA_BIT(8), .DIV_BIT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, " tx"}, 32'(tx), 32'd1);
        chk({tag, " ready"}, 32'(s_ready), 32'd1);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'(exp_done));
    endtask

    // Called just after the accepting edge; returns just after the done edge.
    task automatic check_frame(input logic [7:0] d, input int div, input bit pen,
                               input bit pbit, input bit s2, input bit tweak);
        logic e [0:11];
        int   n;
        e[0] = 1'b0;
        for (int i = 0; i < 8; i++) e[1+i] = d[i];
        n = 9;
        if (pen) begin
            e[n] = pbit;
            n++;
        end
        e[n] = 1'b1;
        n++;
        if (s2) begin
            e[n] = 1'b1;
            n++;
        end
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c <= div; c++) begin
                if (tweak && b == 4 && c == 0) begin
                    baud_div  = 16'd7;
                    parity_en = 1'b1;
                end
                chk($sformatf("d%02h b%0d c%0d tx", d, b, c), 32'(tx), 32'(e[b]));
                chk($sformatf("d%02h b%0d busy", d, b), 32'(busy), 32'd1);
                chk($sformatf("d%02h b%0d ready", d, b), 32'(s_ready), 32'd0);
                chk($sformatf("d%02h b%0d done", d, b), 32'(done), 32'd0);
                step();
            end
        end
        chk_idle($sformatf("d%02h end", d), 1'b1);
    endtask

    initial begin
        reset      = 1'b1;
        baud_div   = 16'd0;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        stop2      = 1'b0;
        s_data     = 8'h00;
        s_valid    = 1'b0;

        // reset state
        #3;
        chk("rst tx", 32'(tx), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst ready", 32'(s_ready), 32'd0);
        step();
        step();
        chk("rst ready held", 32'(s_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("rel ready", 32'(s_ready), 32'd1);

        // idle with no data
        for (int i = 0; i < 20; i++) begin
            step();
            chk_idle($sformatf("idle %0d", i), 1'b0);
        end

        // 0xA5, div 3, no parity, 1 stop: 40 clocks
        baud_div = 16'd3;
        s_data   = 8'hA5;
        s_valid  = 1'b1;
        step();
        s_valid  = 1'b0;
        t0 = cyc;
        check_frame(8'hA5, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("a5 len", 32'(cyc - t0), 32'd40);
        step();
        chk_idle("a5 after", 1'b0);

        // 0x07 even parity -> 1
        baud_div  = 16'd0;
        parity_en = 1'b1;
        s_data    = 8'h07;
        s_valid   = 1'b1;
        step();
        s_valid   = 1'b0;
        t0 = cyc;
        check_frame(8'h07, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("07e len", 32'(cyc - t0), 32'd11);

        // 0x07 odd parity -> 0
        parity_odd = 1'b1;
        s_valid    = 1'b1;
        step();
        s_valid    = 1'b0;
        check_frame(8'h07, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();

        // back-to-back stream 0x01..0x05, 2 stop bits
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        stop2      = 1'b1;
        s_data     = 8'h01;
        s_valid    = 1'b1;
        t0 = cyc;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 5) s_valid = 1'b0;
            else s_data = 8'(i + 1);
            check_frame(8'(i), 0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("stream len", 32'(cyc - t0), 32'd60);
        step();
        chk_idle("stream after", 1'b0);

        // settings changed mid-frame only affect the next frame
        stop2    = 1'b0;
        baud_div = 16'd3;
        s_data   = 8'h3C;
        s_valid  = 1'b1;
        step();
        s_valid  = 1'b0;
        t0 = cyc;
        check_frame(8'h3C, 3, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("3c len", 32'(cyc - t0), 32'd40);
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        t0 = cyc;
        check_frame(8'h3C, 7, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("3c new len", 32'(cyc - t0), 32'd88);

        // reset during data bit 4 of 0x0F
        baud_div  = 16'd3;
        parity_en = 1'b0;
        s_data    = 8'h0F;
        s_valid   = 1'b1;
        step();
        s_valid   = 1'b0;
        for (int i = 0; i < 21; i++) step();
        chk("ab bit4 tx", 32'(tx), 32'd0);
        chk("ab bit4 busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ab tx", 32'(tx), 32'd1);
        chk("ab busy", 32'(busy), 32'd0);
        chk("ab done", 32'(done), 32'd0);
        chk("ab ready", 32'(s_ready), 32'd0);
        step();
        chk("ab done2", 32'(done), 32'd0);
        reset = 1'b0;
        #1;
        chk("ab rel ready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk_idle($sformatf("ab idle %0d", i), 1'b0);
        end

        // next byte after abort: 0x5A, div 1, odd parity -> 1
        baud_div   = 16'd1;
        parity_en  = 1'b1;
        parity_odd = 1'b1;
        s_data     = 8'h5A;
        s_valid    = 1'b1;
        step();
        s_valid    = 1'b0;
        t0 = cyc;
        check_frame(8'h5A, 1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("5a len", 32'(cyc - t0), 32'd22);
        step();
        chk_idle("final", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_stream.md
UART_TX_STREAM -- requirements
Module: uart_tx_stream

Interface
REQ-001 Parameter DATA_BIT, default 8: data bits per frame and width of s_data.
REQ-002 Parameter DIV_BIT, default 16: width of baud_div.
REQ-003 clk  input  1: single clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 baud_div  input  DIV_BIT: clocks per bit minus 1.
REQ-006 parity_en  input  1: 1 = append a parity bit.
REQ-007 parity_odd  input  1: 1 = odd parity, 0 = even parity.
REQ-008 stop2  input  1: 1 = two stop bits, 0 = one stop bit.
REQ-009 s_data  input  DATA_BIT: byte to transmit; connects to the sync FIFO read data.
REQ-010 s_valid  input  1: s_data valid; connects to the FIFO r_valid.
REQ-011 s_ready  output  1: block accepts s_data; drives the FIFO r_ready.
REQ-012 tx  output  1: serial line, idle high.
REQ-013 busy  output  1: frame in progress.
REQ-014 done  output  1: one-cycle pulse at frame end.

Function
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; busy SHALL be 1 whenever state is not IDLE.
REQ-016 s_ready SHALL be 1 in IDLE only; transfer SHALL occur on an edge where s_valid and s_ready are both 1; s_valid SHALL be ignored at all other times.
REQ-017 On transfer, the block SHALL latch s_data, baud_div, parity_en, parity_odd and stop2, then enter START; input changes during a frame SHALL have no effect.
REQ-018 Each bit SHALL last exactly latched baud_div+1 clocks; baud_div=0 SHALL give 1 clock per bit; a down-counter reloads at every bit boundary.
REQ-019 START: tx=0 for one bit time, then DATA.
REQ-020 DATA: bits sent LSB first, DATA_BIT bit times; bit index counter width clog2(DATA_BIT)+1; then PARITY if parity_en, else STOP.
REQ-021 PARITY: tx = XOR of latched data bits, inverted when parity_odd; one bit time.
REQ-022 STOP: tx=1 for 1 bit time, or 2 if stop2; on the last clock, the block SHALL move to IDLE and pulse done for exactly that cycle.
REQ-023 tx SHALL be driven from a register, glitch-free, with no combinational path from inputs.
REQ-024 The first tx=0 SHALL appear the cycle after transfer; frame length = (1+DATA_BIT+parity_en+1+stop2)*(baud_div+1) clocks.
REQ-025 With s_valid held high, frames SHALL run back-to-back with exactly one IDLE clock (tx=1, s_ready=1) between them.
REQ-026 When s_valid=1 arrives in the same cycle that done is high, the transfer SHALL be accepted on that edge, with no extra gap.

Reset
REQ-027 Reset SHALL force asynchronously: state=IDLE, tx=1, busy=0, done=0, all counters and latches 0.
REQ-028 s_ready SHALL be 0 while reset=1 and 1 in the first cycle after release.
REQ-029 Reset mid-frame SHALL abort the frame with no done pulse; the byte SHALL be lost, with no retransmit.

Verification
REQ-030 baud_div=3, no parity, 1 stop, send 0xA5 -> tx: 0 x4, then 1,0,1,0,0,1,0,1 x4 clocks each, then 1 x4; done pulses once at clock 40; s_ready=0 throughout.
REQ-031 baud_div=0, parity_en=1, even parity, send 0x07 -> parity bit 1; repeat with odd parity -> parity bit 0; frame 11 clocks.
REQ-032 baud_div=0, stop2=1, s_valid held with 0x01..0x05 from the FIFO -> five frames of 11 clocks, each followed by one IDLE clock; 60 clocks total; bytes in order; done x5.
REQ-033 Change baud_div 3->7 and parity_en 0->1 during DATA of 0x3C -> current frame unchanged (40 clocks, no parity); the next frame uses the new settings.
REQ-034 Assert reset during DATA bit 4 -> tx=1, busy=0 within the same cycle without a clock edge; no done; after release, s_ready=1 and the next byte is transmitted correctly.
REQ-035 s_valid=0 for 20 clocks after reset -> tx=1, s_ready=1, busy=0, done=0 throughout.
